dsram_responder: RTL and testbench

Data-side SRAM responder for the pipelined CPU. It answers the data_sram request interface that the execute stage drives. It returns data_sram_rdata exactly one clock after a request, which is the cycle in which the memory stage samples it. It provides a word-addressed backing array with byte-lane writes, out-of-range detection, and saturating access counters for the trace/debug harness.

---
 rtl/dsram_responder.sv | 138 +++++++++++++
 tb/tb_dsram_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Data-side SRAM responder: byte-lane word array, sticky out-of-range flag, saturating stats; DSRAM_WBUF_EN adds a one-entry posted write buffer.
// Latency: data_sram_rdata is registered, valid exactly one cycle after an accepted request.
// Backpressure: none; every cycle with data_sram_en high is accepted.
module dsram_responder #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        err_oob,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic        dbg_wbuf_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              r_err_oob;
  logic [31:0]       r_rd_cnt;
  logic [31:0]       r_wr_cnt;

  logic [ADDR_W-1:0] w_idx;
  logic              w_oob;
  logic              w_acc;
  logic              w_rd;
  logic              w_wr;
  logic [31:0]       w_bmask;
  logic [31:0]       w_arr;
  logic [31:0]       w_cur;
  logic [31:0]       w_new;
  logic              w_unused_addr;

  assign w_idx         = data_sram_addr[ADDR_W+1:2];
  assign w_oob         = |data_sram_addr[31:ADDR_W+2];
  // Requests held high while in reset must not touch the array.
  assign w_acc         = data_sram_en && resetn;
  assign w_rd          = w_acc && !w_oob && (data_sram_wen == 4'b0000);
  assign w_wr          = w_acc && !w_oob && (data_sram_wen != 4'b0000);
  assign w_unused_addr = ^data_sram_addr[1:0];

  assign w_bmask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                    {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign w_arr   = r_mem[w_idx];
  // For a read the mask is zero, so w_new is simply the current word.
  assign w_new   = (w_cur & ~w_bmask) | (data_sram_wdata & w_bmask);

`ifdef DSRAM_WBUF_EN
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [3:0]        wen;
    logic [31:0]       dat;
  } wbuf_t;

  logic        r_wb_vld;
  wbuf_t       r_wb;
  logic [31:0] w_wb_bmask;
  logic        w_wb_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb_vld <= 1'b0;
      r_wb     <= '0;
    end else begin
      r_wb_vld <= w_wr;
      if (w_wr) begin
        r_wb.idx <= w_idx;
        r_wb.wen <= data_sram_wen;
        r_wb.dat <= data_sram_wdata;
      end
    end
  end

  assign w_wb_bmask = {{8{r_wb.wen[3]}}, {8{r_wb.wen[2]}},
                       {8{r_wb.wen[1]}}, {8{r_wb.wen[0]}}};
  assign w_wb_hit   = r_wb_vld && (r_wb.idx == w_idx);
  // Forward the pending lanes so the buffer is invisible on rdata.
  assign w_cur      = w_wb_hit ? ((w_arr & ~w_wb_bmask) | (r_wb.dat & w_wb_bmask)) : w_arr;

  // A held entry always commits on the next edge; a new write just replaces it.
  always_ff @(posedge clk) begin
    if (r_wb_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wb.wen[i]) r_mem[r_wb.idx][8*i +: 8] <= r_wb.dat[8*i +: 8];
      end
    end
  end

  assign dbg_wbuf_valid = r_wb_vld;
`else
  assign w_cur = w_arr;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign dbg_wbuf_valid = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata   <= 32'h0;
      r_err_oob <= 1'b0;
    end else if (data_sram_en) begin
      if (w_oob) begin
        r_rdata   <= 32'h0;
        r_err_oob <= 1'b1;
      end else begin
        r_rdata   <= w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_cnt <= 32'h0;
      r_wr_cnt <= 32'h0;
    end else begin
      if (w_rd && (r_rd_cnt != 32'hFFFF_FFFF)) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_wr && (r_wr_cnt != 32'hFFFF_FFFF)) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign err_oob         = r_err_oob;
  assign stat_rd_cnt     = r_rd_cnt;
  assign stat_wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: directed scenarios plus random traffic against a word-level reference model.
module tb_dsram_responder;
  localparam int ADDR_W = 12;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        en     = 1'b0;
  logic [3:0]  wen    = 4'h0;
  logic [31:0] addr   = 32'h0;
  logic [31:0] wdata  = 32'h0;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        wbv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .err_oob         (err),
    .stat_rd_cnt     (rd_cnt),
    .stat_wr_cnt     (wr_cnt),
    .dbg_wbuf_valid  (wbv)
  );

  // Reference model: word contents by index plus expected visible outputs.
  logic [31:0] m_mem [int unsigned];
  logic [31:0] e_rdata;
  bit          e_known;
  logic        e_err;
  logic [31:0] e_rd;
  logic [31:0] e_wr;
  logic        e_wbv;

  function automatic void model_reset();
    e_rdata = 32'h0;
    e_known = 1'b1;
    e_err   = 1'b0;
    e_rd    = 32'h0;
    e_wr    = 32'h0;
    e_wbv   = 1'b0;
  endfunction

  function automatic void model_req(input logic r_en, input logic [3:0] r_wen,
                                    input logic [31:0] r_addr, input logic [31:0] r_wdata);
    int unsigned idx;
    logic [31:0] w;
    e_wbv = 1'b0;
    if (!r_en) return;
    if ((r_addr >> (ADDR_W + 2)) != 0) begin
      e_rdata = 32'h0;
      e_known = 1'b1;
      e_err   = 1'b1;
      return;
    end
    idx = r_addr >> 2;
    if (r_wen == 4'h0) begin
      e_known = m_mem.exists(idx);
      if (e_known) e_rdata = m_mem[idx];
      if (e_rd != 32'hFFFF_FFFF) e_rd = e_rd + 1;
    end else begin
      if (m_mem.exists(idx) || r_wen == 4'hF) begin
        w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (r_wen[i]) w[8*i +: 8] = r_wdata[8*i +: 8];
        m_mem[idx] = w;
        e_rdata = w;
        e_known = 1'b1;
      end else begin
        e_known = 1'b0;
      end
      if (e_wr != 32'hFFFF_FFFF) e_wr = e_wr + 1;
`ifdef DSRAM_WBUF_EN
      e_wbv = 1'b1;
`endif
    end
  endfunction

  task automatic issue(input logic r_en, input logic [3:0] r_wen,
                       input logic [31:0] r_addr, input logic [31:0] r_wdata);
    en = r_en; wen = r_wen; addr = r_addr; wdata = r_wdata;
    model_req(r_en, r_wen, r_addr, r_wdata);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", err); end
    n_checks++; if (rd_cnt !== 32'h0) begin n_errors++; $display("FAIL reset_rd_cnt got=%h want=0", rd_cnt); end
    n_checks++; if (wr_cnt !== 32'h0) begin n_errors++; $display("FAIL reset_wr_cnt got=%h want=0", wr_cnt); end
    n_checks++; if (wbv !== 1'b0) begin n_errors++; $display("FAIL reset_wbv got=%b want=0", wbv); end
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      issue(1'b0, 4'h0, 32'h0, 32'h0);
      n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_idle_rdata cyc=%0d got=%h want=0", c, rdata); end
    end
  endtask

  task automatic test_byte_lane();
    issue(1'b1, 4'hF, 32'h10, 32'h1122_3344);
    issue(1'b1, 4'h5, 32'h10, 32'hAABB_CCDD);
    n_checks++; if (rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL lane_write_rdata got=%h want=11bb33dd", rdata); end
    issue(1'b1, 4'h0, 32'h12, 32'h0);
    n_checks++; if (rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL lane_read_rdata got=%h want=11bb33dd", rdata); end
    n_checks++; if (wr_cnt !== 32'd2) begin n_errors++; $display("FAIL lane_wr_cnt got=%0d want=2", wr_cnt); end
    n_checks++; if (rd_cnt !== 32'd1) begin n_errors++; $display("FAIL lane_rd_cnt got=%0d want=1", rd_cnt); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
    n_checks++; if (wbv !== e_wbv) begin n_errors++; $display("FAIL raw_wbv_w1 got=%b want=%b", wbv, e_wbv); end
    issue(1'b1, 4'h0, 32'h20, 32'h0);
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL raw_read got=%h want=deadbeef", rdata); end
    issue(1'b1, 4'hF, 32'h24, 32'h1);
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL raw_w2_rdata got=%h want=1", rdata); end
    n_checks++; if (wbv !== e_wbv) begin n_errors++; $display("FAIL raw_wbv_w2 got=%b want=%b", wbv, e_wbv); end
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    n_checks++; if (wbv !== 1'b0) begin n_errors++; $display("FAIL raw_wbv_idle got=%b want=0", wbv); end
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL raw_idle_hold got=%h want=1", rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  m;
    logic        e;
    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, i * 4, $urandom);
    for (int c = 0; c < 400; c++) begin
      e = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_4000;
      else a = {26'h0, 4'($urandom), 2'($urandom)};
      issue(e, m, a, d);
      if (e_known) begin
        n_checks++; if (rdata !== e_rdata) begin n_errors++; $display("FAIL rand_rdata cyc=%0d addr=%h got=%h want=%h", c, a, rdata, e_rdata); end
      end
      n_checks++; if (err !== e_err) begin n_errors++; $display("FAIL rand_err cyc=%0d got=%b want=%b", c, err, e_err); end
      n_checks++; if (rd_cnt !== e_rd) begin n_errors++; $display("FAIL rand_rd_cnt cyc=%0d got=%0d want=%0d", c, rd_cnt, e_rd); end
      n_checks++; if (wr_cnt !== e_wr) begin n_errors++; $display("FAIL rand_wr_cnt cyc=%0d got=%0d want=%0d", c, wr_cnt, e_wr); end
      n_checks++; if (wbv !== e_wbv) begin n_errors++; $display("FAIL rand_wbv cyc=%0d got=%b want=%b", c, wbv, e_wbv); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] wr_before;
    wr_before = e_wr;
    issue(1'b1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL oob_rdata got=%h want=0", rdata); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL oob_err got=%b want=1", err); end
    n_checks++; if (wr_cnt !== wr_before) begin n_errors++; $display("FAIL oob_wr_cnt got=%0d want=%0d", wr_cnt, wr_before); end
    issue(1'b1, 4'hF, 32'h0, 32'h5A5A_5A5A);
    issue(1'b1, 4'h0, 32'h0, 32'h0);
    n_checks++; if (rdata !== 32'h5A5A_5A5A) begin n_errors++; $display("FAIL oob_follow_read got=%h want=5a5a5a5a", rdata); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL oob_sticky got=%b want=1", err); end
  endtask

  task automatic test_saturation();
    force dut.r_rd_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_rd_cnt;
    #1;
    e_rd = 32'hFFFF_FFFE;
    n_checks++; if (rd_cnt !== e_rd) begin n_errors++; $display("FAIL sat_preload got=%h want=%h", rd_cnt, e_rd); end
    for (int c = 0; c < 3; c++) begin
      issue(1'b1, 4'h0, 32'h0, 32'h0);
      n_checks++; if (rd_cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_rd_cnt n=%0d got=%h want=ffffffff", c, rd_cnt); end
      n_checks++; if (rdata !== e_rdata) begin n_errors++; $display("FAIL sat_rdata n=%0d got=%h want=%h", c, rdata, e_rdata); end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; wen = 4'hF; addr = 32'h30; wdata = 32'h1234_5678;
    model_req(1'b1, 4'hF, 32'h30, 32'h1234_5678);
    @(posedge clk); #1;
    en = 1'b0;
    #4;
    resetn = 1'b0;
    #1;
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL mid_rdata got=%h want=0", rdata); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mid_err got=%b want=0", err); end
    n_checks++; if (rd_cnt !== 32'h0) begin n_errors++; $display("FAIL mid_rd_cnt got=%h want=0", rd_cnt); end
    n_checks++; if (wr_cnt !== 32'h0) begin n_errors++; $display("FAIL mid_wr_cnt got=%h want=0", wr_cnt); end
    n_checks++; if (wbv !== 1'b0) begin n_errors++; $display("FAIL mid_wbv got=%b want=0", wbv); end
    model_reset();
`ifdef DSRAM_WBUF_EN
    m_mem.delete(32'h30 >> 2);
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 4'h0, 32'h30, 32'h0);
    if (e_known) begin
      n_checks++; if (rdata !== e_rdata) begin n_errors++; $display("FAIL mid_read got=%h want=%h", rdata, e_rdata); end
    end
    n_checks++; if (rd_cnt !== 32'd1) begin n_errors++; $display("FAIL mid_read_cnt got=%0d want=1", rd_cnt); end
    n_checks++; if (wbv !== 1'b0) begin n_errors++; $display("FAIL mid_read_wbv got=%b want=0", wbv); end
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
